rr_arb_4x_nbit: RTL and testbench
=================================

// Module: rr_arb_4x_nbit
// PURPOSE
//   Round-robin arbiter and output register sitting directly upstream of the
//   4:1 n-bit mux. It takes four requesting sources (a..d) with valid/ack
//   handshakes and picks one per cycle with fair rotating priority. It presents
//   the winner as a registered stream (y/y_valid/y_ready).
//   sel carries the registered grant index so a downstream mux_4x_nbit, or any
//   sibling datapath mux, can steer its own bus in lockstep.
// PARAMETERS
//   BUS_WIDTH   8   width of each source data bus and of y
// PORTS
//   clk       in   1          single clock, all state on rising edge
//   reset     in   1          synchronous, active-high reset
//   req       in   4          req[i]=1: source i (0=a,1=b,2=c,3=d) has valid data
//   a         in   BUS_WIDTH  source 0 data, stable while req[0] && !ack[0]
//   b         in   BUS_WIDTH  source 1 data
//   c         in   BUS_WIDTH  source 2 data
//   d         in   BUS_WIDTH  source 3 data
//   ack       out  4          one-hot (or zero), comb.: source i consumed this cycle
//   sel       out  2          registered index of the source currently held in y
//   y         out  BUS_WIDTH  registered output data
//   y_valid   out  1          y holds an unconsumed word
//   y_ready   in   1          downstream accepts y this cycle
// BEHAVIOUR
//   Reset (clk edge with reset=1): y_valid=0, y=0, sel=0, ptr=0.
//     Reset overrides all other activity; a held word is dropped, not delivered.
//     While reset=1, ack=0.
//   State: output register {y, sel, y_valid} plus 2-bit priority pointer ptr.
//     Two output states: EMPTY (y_valid=0) and FULL (y_valid=1).
//   load_en = !y_valid || y_ready. This is a full-throughput pipeline with no bubble.
//   Grant, combinational: scan req at ptr, ptr+1, ptr+2, ptr+3 (mod 4); the
//     first set bit wins (gnt). any_req = |req.
//   ack[gnt] = load_en && any_req && !reset; all other ack bits are 0.
//     ack depends only on req, ptr, y_valid, y_ready and reset, never on data.
//   On the clk edge, when load_en:
//     any_req=1 -> y<=data[gnt], sel<=gnt, y_valid<=1, ptr<=gnt+1 (3 wraps to 0).
//     any_req=0 -> y_valid<=0; y, sel and ptr hold.
//   When !load_en (FULL, y_ready=0): y, sel, y_valid and ptr hold; ack=0.
//   Latency: req asserted at cycle N with load_en -> y_valid=1 at N+1.
//     Sustained throughput is one word per cycle while y_ready=1.
//   Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0...
//     No source waits more than 3 grants after it asserts req.
//   Transitions:
//     EMPTY -> FULL when any_req.
//     FULL -> FULL when (y_ready && any_req) or !y_ready.
//     FULL -> EMPTY when y_ready && !any_req.
//   Simultaneous events:
//     y_ready with a new grant in the same cycle replaces y back-to-back.
//     req dropped in the same cycle it would be granted is not granted; the
//       scan uses current req only.
//   y_ready while EMPTY is ignored. Sources may drop req only after ack.
// TESTING
//   1 Reset: hold reset 2 cycles with req=4'hF -> ack=0, y_valid=0, y=0, sel=0.
//   2 Single: ptr=0, req=4'b0100, c=8'h5A, y_ready=1 -> ack=4'b0100 that cycle;
//     next cycle y=8'h5A, sel=2, y_valid=1; ptr=3.
//   3 Rotation: req=4'hF held, y_ready=1, a..d=11,22,33,44 (hex) ->
//     sel sequence 0,1,2,3,0; y 11,22,33,44,11; ack one-hot every cycle.
//   4 Backpressure: FULL with y=22, y_ready=0 for 3 cycles, req=4'hF ->
//     y, sel, ptr frozen, ack=0; on y_ready=1, next grant is source ptr.
//   5 Wrap/skip: ptr=3, req=4'b0011 -> grant 0 (sel=0), then ptr=1 -> grant 1.
//   6 Reset mid-op: FULL y=8'h44, reset for 1 cycle -> y_valid=0, ptr=0;
//     the next req=4'hF grants source 0.

Source files
------------

// File: rtl/rr_arb_4x_nbit.sv
// rr_arb_4x_nbit
//   Round-robin arbiter with a registered output stage, placed upstream of a
//   4:1 n-bit mux. Four sources (a..d) raise req; one is granted per cycle
//   with rotating priority. The winner's data is captured into y, and its
//   index is captured into sel so that sibling muxes can steer in lockstep.
//
// Ports
//   clk      in   1          rising-edge clock
//   reset    in   1          synchronous, active-high reset
//   req      in   4          req[i]: source i (0=a,1=b,2=c,3=d) has valid data
//   a..d     in   BUS_WIDTH  source data, held stable until acknowledged
//   ack      out  4          combinational one-hot (or zero): source consumed
//   sel      out  2          registered index of the source held in y
//   y        out  BUS_WIDTH  registered output data
//   y_valid  out  1          y holds an unconsumed word
//   y_ready  in   1          downstream accepts y this cycle
module rr_arb_4x_nbit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [3:0]           ack,
  output logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   y_q, y_d;
  logic [1:0]             sel_q, sel_d;
  logic [1:0]             ptr_q, ptr_d;

  logic                   load_en_s;
  logic                   any_req_s;
  logic [7:0]             req_dbl_s;
  logic [3:0]             req_rot_s;
  logic [1:0]             offs_s;
  logic [1:0]             gnt_s;
  logic [BUS_WIDTH-1:0]   gnt_data_s;

  // The output register can take a new word when it is empty or being drained.
  assign load_en_s = (state_q == ST_EMPTY) || y_ready;

  // Rotating-priority grant: rotate req so ptr lands on bit 0, priority-encode
  // the rotated vector, then add ptr back to recover the absolute index.
  always_comb begin
    req_dbl_s = {req, req};
    req_rot_s = req_dbl_s[ptr_q +: 4];
    any_req_s = |req;
    casez (req_rot_s)
      4'b???1: offs_s = 2'd0;
      4'b??10: offs_s = 2'd1;
      4'b?100: offs_s = 2'd2;
      4'b1000: offs_s = 2'd3;
      default: offs_s = 2'd0;
    endcase
    gnt_s = ptr_q + offs_s;
  end

  // Select the granted source's data bus.
  always_comb begin
    case (gnt_s)
      2'd0:    gnt_data_s = a;
      2'd1:    gnt_data_s = b;
      2'd2:    gnt_data_s = c;
      2'd3:    gnt_data_s = d;
      default: gnt_data_s = a;
    endcase
  end

  // Acknowledge the winner only when its word is actually captured this cycle.
  always_comb begin
    ack = 4'b0000;
    if (load_en_s && any_req_s && !reset) begin
      ack[gnt_s] = 1'b1;
    end else begin
      ack = 4'b0000;
    end
  end

  // Next-state for the output register and priority pointer.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load_en_s) begin
      if (any_req_s) begin
        state_d = ST_FULL;
        y_d     = gnt_data_s;
        sel_d   = gnt_s;
        ptr_d   = gnt_s + 2'd1;   // 2-bit add wraps 3 -> 0
      end else begin
        state_d = ST_EMPTY;       // drained with nothing to replace it
      end
    end else begin
      state_d = state_q;
      y_d     = y_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
    end
  end

  // State register with synchronous reset; a held word is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      y_q     <= {BUS_WIDTH{1'b0}};
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_rr_arb_4x_nbit.sv
module tb_rr_arb_4x_nbit;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;

  int checks;
  int errors;

  // Expected words {sel, y}, pushed by stimulus, popped by the monitor.
  logic [9:0] exp_q[$];

  rr_arb_4x_nbit #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .ack     (ack),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i[1:0];
    return r;
  endfunction

  function automatic logic [7:0] src_data(input logic [1:0] idx);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive req/y_ready, check ack, optionally queue the granted word,
  // then advance to just after the capturing edge.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] exp_ack,
                     input logic do_push, input string name);
    logic [1:0] idx;
    req     = r;
    y_ready = rdy;
    #1;
    chk(name, {28'd0, ack}, {28'd0, exp_ack});
    if (do_push && exp_ack != 4'b0000) begin
      idx = onehot_idx(exp_ack);
      exp_q.push_back({idx, src_data(idx)});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a word is consumed, compare it with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got sel=%0d y=%0h expected no word", sel, y);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({sel, y} !== e) begin
          errors++;
          $display("FAIL mon_word: got sel=%0d y=%0h expected sel=%0d y=%0h",
                   sel, y, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    req     = 4'hF;
    y_ready = 1'b0;
    a = 8'h11; b = 8'h22; c = 8'h5A; d = 8'h44;

    // Reset held two cycles with all sources requesting.
    #1;
    chk("rst_ack0", {28'd0, ack}, 32'd0);
    @(posedge clk); #1;
    chk("rst_ack1", {28'd0, ack}, 32'd0);
    chk("rst_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    @(posedge clk); #1;
    chk("rst_valid2", {31'd0, y_valid}, 32'd0);
    reset = 1'b0;

    // Single request from c with ptr=0.
    cyc(4'b0100, 1'b1, 4'b0100, 1'b1, "single_ack");
    chk("single_y", {24'd0, y}, 32'h5A);
    chk("single_sel", {30'd0, sel}, 32'd2);
    chk("single_valid", {31'd0, y_valid}, 32'd1);
    c = 8'h33;
    // ptr should now be 3: with all requesting, d wins.
    cyc(4'hF, 1'b1, 4'b1000, 1'b1, "ptr3_ack");

    // Rotation from ptr=0.
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, "rot0_ack");
    cyc(4'hF, 1'b1, 4'b0010, 1'b1, "rot1_ack");
    cyc(4'hF, 1'b1, 4'b0100, 1'b1, "rot2_ack");
    cyc(4'hF, 1'b1, 4'b1000, 1'b1, "rot3_ack");
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, "rot4_ack");
    chk("rot4_y", {24'd0, y}, 32'h11);

    // Backpressure with y=22 held.
    cyc(4'hF, 1'b1, 4'b0010, 1'b1, "bp_load_ack");
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, 1'b0, 4'b0000, 1'b1, "bp_hold_ack");
      chk("bp_hold_y", {24'd0, y}, 32'h22);
      chk("bp_hold_sel", {30'd0, sel}, 32'd1);
      chk("bp_hold_valid", {31'd0, y_valid}, 32'd1);
    end
    cyc(4'hF, 1'b1, 4'b0100, 1'b1, "bp_release_ack");

    // Wrap and skip: ptr=3, only a and b requesting.
    cyc(4'b0011, 1'b1, 4'b0001, 1'b1, "wrap_ack");
    chk("wrap_sel", {30'd0, sel}, 32'd0);
    cyc(4'b0011, 1'b1, 4'b0010, 1'b1, "skip_ack");
    chk("skip_sel", {30'd0, sel}, 32'd1);

    // Drain to EMPTY, then y_ready while empty is ignored.
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "drain_ack");
    chk("drain_valid", {31'd0, y_valid}, 32'd0);
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "empty_ack");
    chk("empty_valid", {31'd0, y_valid}, 32'd0);

    // Reset mid-operation drops a held word (ptr=2 here, so d wins).
    cyc(4'b1000, 1'b0, 4'b1000, 1'b0, "mid_load_ack");
    chk("mid_y", {24'd0, y}, 32'h44);
    reset = 1'b1;
    cyc(4'hF, 1'b0, 4'b0000, 1'b0, "mid_rst_ack");
    chk("mid_rst_valid", {31'd0, y_valid}, 32'd0);
    chk("mid_rst_y", {24'd0, y}, 32'd0);
    chk("mid_rst_sel", {30'd0, sel}, 32'd0);
    reset = 1'b0;
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, "post_rst_ack");
    chk("post_rst_sel", {30'd0, sel}, 32'd0);
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "final_drain_ack");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "final_idle_ack");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
